instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Program-buffer sequencer sitting directly upstream of the vector processor. It stores a short program of 13-bit processor instructions written by a host, then issues them to the processor's `instruction` input one per cycle on command, with a valid qualifier, hold (stall) support and a completion pulse. The processor samples `instruction` only when `instr_valid` is high.

## Interface
- `DEPTH`, 16: program buffer entries (power of two, ≥2).
- `IDLE_INSTR`, 13'h0000: value driven on `instruction` whenever `instr_valid`=0.
- `AW`, $clog2(DEPTH): buffer address width (derived, not overridden).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `prog_we`  in  1  program buffer write strobe.
- `prog_addr`  in  AW  write address.
- `prog_data`  in  13  instruction to store.
- `start`  in  1  begin executing entries 0..`len`-1.
- `len`  in  AW+1  program length, sampled with `start`; range 0..DEPTH.
- `hold`  in  1  stall: no issue while high.
- `instruction`  out  13  instruction to processor (registered).
- `instr_valid`  out  1  `instruction` is a real issue this cycle.
- `pc`  out  AW+1  index of next entry to issue.
- `busy`  out  1  state is RUN.
- `done`  out  1  one-cycle pulse when the program completes.

## Operation
- Instruction format carried untouched: [12:11] opcode (00 store A3, 01 load, 10 add, 11 multiply), [10:9] register select, [8:0] address.
- States: IDLE, RUN.
- IDLE: `prog_we`=1 writes `prog_data` to buffer[`prog_addr`]. `start`=1 latches `len`, sets `pc`←0, → RUN. If `prog_we` and `start` coincide, the write completes and is visible to the run.
- RUN, `hold`=1: `instr_valid`←0, `instruction`←`IDLE_INSTR`, `pc` unchanged, no completion check.
- RUN, `hold`=0, `pc`<`len`: `instruction`←buffer[`pc`], `instr_valid`←1, `pc`←`pc`+1.
- RUN, `hold`=0, `pc`==`len`: `instr_valid`←0, `instruction`←`IDLE_INSTR`, `done`←1, → IDLE.
- `start` and `prog_we` ignored in RUN; buffer contents unchanged.
- `len`>DEPTH clamps to DEPTH on latch.
- `len`=0: RUN for one cycle, no issue, then `done`.
- Reset: `instruction`=`IDLE_INSTR`, `instr_valid`=0, `pc`=0, `busy`=0, `done`=0, state IDLE; buffer contents not cleared. Reset mid-run aborts immediately, without `done`.

## Timing
- All outputs registered; no combinational input-to-output path.
- `start` sampled at edge T → `busy`=1 after T; first `instr_valid`=1 after edge T+1 (one idle cycle of start latency).
- With no hold: `len` consecutive valid cycles, entries in order 0..`len`-1; `done`=1 in the cycle immediately after the last valid, together with `busy`=0.
- Each cycle of `hold` adds exactly one bubble; no instruction skipped or duplicated.
- `done` high exactly one cycle; a new `start` is accepted in that cycle.

## Configuration
- `SEQ_LOOP_EN` defined: adds input port `loop` (1 bit). In RUN with `hold`=0, `pc`==`len` and `loop`=1: `pc`←0, `instr_valid`←0 (one bubble), stay RUN, no `done`; `loop`=0 completes as normal. `len`=0 with `loop`=1 idles in RUN until `loop` drops.
- Undefined: no `loop` port; the program always completes once.

## Test plan
- Write 8 entries {0x0800, 0x0A00, 0x17FF, 0x0440, 0x0840, 0x1800, 0x0440, 0x0E40}, `start` with `len`=8 → valid on 8 consecutive cycles starting 2 edges after `start`, exact order, `done` one cycle after the last, `pc`=8.
- Same program, `hold`=1 for 3 cycles after the 2nd issue → 3 bubbles with `instruction`=0x0000, then entries 2..7 resume, no loss or duplication.
- `start` with `len`=0 → no valid cycle, `done` 2 edges after `start`; `start` and `prog_we` during RUN → ignored, buffer readback unchanged.
- `rst` asserted after 3 issues → next cycle all outputs at reset values, no `done`; new `start` re-runs from entry 0 with contents intact.
- `len`=20 (DEPTH=16) → exactly 16 issues, then `done`.
- With `SEQ_LOOP_EN`, `len`=2, `loop`=1 → pattern e0,e1,bubble,e0,e1,… with no `done`; drop `loop` → `done` after the next e1.

Source files
------------

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - program-buffer instruction sequencer feeding the vector processor
//
// Stores up to DEPTH 13-bit instructions written by a host and, on start,
// issues entries 0..len-1 one per cycle with a valid qualifier, hold support
// and a one-cycle completion pulse. All outputs are registered.
//
// Optional feature macro: SEQ_LOOP_EN (adds i_loop; restarts the program
// instead of completing while i_loop is high).
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_prog_we      program buffer write strobe (honoured in IDLE only)
//   i_prog_addr    write address
//   i_prog_data    instruction to store
//   i_start        start executing entries 0..i_len-1 (honoured in IDLE only)
//   i_len          program length, sampled with i_start, clamped to DEPTH
//   i_hold         stall: no issue while high
//   i_loop         (SEQ_LOOP_EN only) loop back to entry 0 at end of program
//   o_instruction  registered instruction, IDLE_INSTR when not valid
//   o_instr_valid  o_instruction is a real issue this cycle
//   o_pc           index of next entry to issue
//   o_busy         sequencer is running
//   o_done         one-cycle pulse on program completion

module instr_sequencer #(
    parameter int          DEPTH      = 16,
    parameter logic [12:0] IDLE_INSTR = 13'h0000,
    localparam int         AW         = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_prog_we,
    input  logic [AW-1:0] i_prog_addr,
    input  logic [12:0]   i_prog_data,
    input  logic          i_start,
    input  logic [AW:0]   i_len,
    input  logic          i_hold,
`ifdef SEQ_LOOP_EN
    input  logic          i_loop,
`endif
    output logic [12:0]   o_instruction,
    output logic          o_instr_valid,
    output logic [AW:0]   o_pc,
    output logic          o_busy,
    output logic          o_done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t      r_state;
    state_t      w_state_next;
    logic [12:0] r_mem [DEPTH];
    logic [AW:0] r_len;
    logic [AW:0] w_len_next;
    logic [AW:0] r_pc;
    logic [AW:0] w_pc_next;
    logic [12:0] r_instr;
    logic [12:0] w_instr_next;
    logic        r_valid;
    logic        w_valid_next;
    logic        r_done;
    logic        w_done_next;
    logic        w_mem_we;
    logic        w_loop;
    logic [AW:0] w_len_clamped;

`ifdef SEQ_LOOP_EN
    assign w_loop = i_loop;
`else
    assign w_loop = 1'b0;
`endif

    assign w_len_clamped = (i_len > DEPTH_W) ? DEPTH_W : i_len;

    always_comb begin
        w_state_next = r_state;
        w_len_next   = r_len;
        w_pc_next    = r_pc;
        w_instr_next = IDLE_INSTR;
        w_valid_next = 1'b0;
        w_done_next  = 1'b0;
        w_mem_we     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A write coinciding with start lands before the first read
                // one cycle later, so the run sees the new entry.
                w_mem_we = i_prog_we;
                if (i_start) begin
                    w_len_next   = w_len_clamped;
                    w_pc_next    = '0;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!i_hold) begin
                    if (r_pc < r_len) begin
                        w_instr_next = r_mem[r_pc[AW-1:0]];
                        w_valid_next = 1'b1;
                        w_pc_next    = r_pc + 1'b1;
                    end else if (w_loop) begin
                        // End of program while looping costs one bubble cycle.
                        w_pc_next = '0;
                    end else begin
                        w_done_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_pc    <= '0;
            r_instr <= IDLE_INSTR;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_len   <= w_len_next;
            r_pc    <= w_pc_next;
            r_instr <= w_instr_next;
            r_valid <= w_valid_next;
            r_done  <= w_done_next;
        end
    end

    // Buffer contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[i_prog_addr] <= i_prog_data;
        end
    end

    assign o_instruction = r_instr;
    assign o_instr_valid = r_valid;
    assign o_pc          = r_pc;
    assign o_busy        = (r_state == S_RUN);
    assign o_done        = r_done;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard testbench for instr_sequencer

module tb_instr_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [12:0]   prog_data;
    logic          start;
    logic [AW:0]   len;
    logic          hold;
`ifdef SEQ_LOOP_EN
    logic          loop;
`endif
    logic [12:0]   instruction;
    logic          instr_valid;
    logic [AW:0]   pc;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    instr_sequencer #(.DEPTH(DEPTH), .IDLE_INSTR(13'h0000)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_prog_we    (prog_we),
        .i_prog_addr  (prog_addr),
        .i_prog_data  (prog_data),
        .i_start      (start),
        .i_len        (len),
        .i_hold       (hold),
`ifdef SEQ_LOOP_EN
        .i_loop       (loop),
`endif
        .o_instruction(instruction),
        .o_instr_valid(instr_valid),
        .o_pc         (pc),
        .o_busy       (busy),
        .o_done       (done)
    );

    logic [12:0] mdl [DEPTH];
    logic [12:0] exp_q [$];
    logic [12:0] mon_exp;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [12:0] prog_tab [DEPTH] = '{
        13'h0800, 13'h0A00, 13'h17FF, 13'h0440, 13'h0840, 13'h1800, 13'h0440, 13'h0E40,
        13'h1001, 13'h0203, 13'h1C05, 13'h0607, 13'h1209, 13'h0A0B, 13'h160D, 13'h1FFF
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid issue must match the next queued expectation;
    // every non-valid cycle must carry the idle instruction.
    always @(negedge clk) begin
        if (!rst) begin
            if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_issue: got %0h expected no issue at %0t", instruction, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("issue_data", {19'd0, instruction}, {19'd0, mon_exp});
                end
            end else begin
                check("idle_instr", {19'd0, instruction}, 32'h0);
            end
        end
    end

    task automatic write_entry(input int a, input logic [12:0] d);
        prog_we   = 1'b1;
        prog_addr = AW'(a);
        prog_data = d;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
        mdl[a]  = d;
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle. Hold is applied on edges
    // hold_at+1 .. hold_at+hold_n after start; poke drives start/prog_we mid-run.
    task automatic run(input int len_in, input int n_issue, input int hold_at,
                       input int hold_n, input bit poke);
        int k;
        bit fired;
        for (int i = 0; i < n_issue; i++) exp_q.push_back(mdl[i]);
        start = 1'b1;
        len   = (AW+1)'(len_in);
        @(posedge clk);
        #1;
        start = 1'b0;
        prog_we = 1'b0;
        @(negedge clk);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("done_low_after_start", {31'd0, done}, 32'd0);
        check("valid_low_after_start", {31'd0, instr_valid}, 32'd0);
        check("pc_zero_after_start", {27'd0, pc}, 32'd0);
        k = 0;
        fired = 1'b0;
        while (k < 100 && !fired) begin
            hold = (k + 1 > hold_at) && (k + 1 <= hold_at + hold_n);
            if (poke && k == 2) begin
                start     = 1'b1;
                len       = 5'd1;
                prog_we   = 1'b1;
                prog_addr = '0;
                prog_data = 13'h1FFF;
            end else begin
                start   = 1'b0;
                prog_we = 1'b0;
            end
            @(negedge clk);
            k++;
            if (done) fired = 1'b1;
        end
        hold    = 1'b0;
        start   = 1'b0;
        prog_we = 1'b0;
        check("done_seen", {31'd0, fired}, 32'd1);
        check("done_cycle", k, n_issue + 1 + hold_n);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("pc_at_done", {27'd0, pc}, n_issue);
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        start     = 1'b0;
        len       = '0;
        hold      = 1'b0;
`ifdef SEQ_LOOP_EN
        loop      = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_instr", {19'd0, instruction}, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_pc", {27'd0, pc}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < DEPTH; i++) write_entry(i, prog_tab[i]);

        // Plain run, then back-to-back runs starting in the done cycle.
        run(8, 8, 1000, 0, 1'b0);
        run(8, 8, 2, 3, 1'b0);
        run(0, 0, 1000, 0, 1'b0);
        // start/prog_we during RUN must be ignored; next run proves buffer intact.
        run(8, 8, 1000, 0, 1'b1);
        run(8, 8, 1000, 0, 1'b0);
        // Over-length clamps to DEPTH.
        run(20, 16, 1000, 0, 1'b0);

        // Write coinciding with start is visible to the run.
        prog_we   = 1'b1;
        prog_addr = '0;
        prog_data = 13'h1555;
        mdl[0]    = 13'h1555;
        run(1, 1, 1000, 0, 1'b0);
        write_entry(0, 13'h0800);

        // Reset after three issues aborts without done; contents survive.
        for (int i = 0; i < 3; i++) exp_q.push_back(mdl[i]);
        start = 1'b1;
        len   = 5'd8;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_valid", {31'd0, instr_valid}, 32'd0);
        check("abort_instr", {19'd0, instruction}, 32'h0);
        check("abort_pc", {27'd0, pc}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_queue", exp_q.size(), 32'd0);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        run(8, 8, 1000, 0, 1'b0);

`ifdef SEQ_LOOP_EN
        // len=2 looping: e0 e1 bubble e0 e1 bubble e0 e1 done.
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back(mdl[0]);
            exp_q.push_back(mdl[1]);
        end
        loop  = 1'b1;
        start = 1'b1;
        len   = 5'd2;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 9; k++) begin
            if (k == 8) loop = 1'b0;
            @(negedge clk);
            check("loop_done", {31'd0, done}, (k == 9) ? 32'd1 : 32'd0);
            if (k == 3 || k == 6) check("loop_bubble", {31'd0, instr_valid}, 32'd0);
        end
        check("loop_queue", exp_q.size(), 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 32'd0);
        check("final_idle", {31'd0, busy}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
